// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot_product block.
//   DATA_W     : width of every data element and of the result
//   VEC_LEN    : number of elements per operand vector
//   Q_BITS_DEF : default number of fractional bits of the fixed-point format
//   PROD_W     : full signed product width
//   SUM_W      : accumulator width (two guard bits over PROD_W for three terms)
//   vec3_t     : operand vector, element i at [i]
package dot_product_pkg;

    localparam int DATA_W     = 32;
    localparam int VEC_LEN    = 3;
    localparam int Q_BITS_DEF = 10;
    localparam int PROD_W     = 2 * DATA_W;
    localparam int SUM_W      = PROD_W + 2;

    typedef logic signed [VEC_LEN-1:0][DATA_W-1:0] vec3_t;

endpackage

// File: rtl/dot_product_fifo_array.sv
// fifo_array: synchronous first-word-fall-through FIFO.
//   clk_i, rst_i  : clock, asynchronous active-high reset (pointers/count only)
//   wr_en_i       : write wr_data_i at the rising edge (dropped if full and no read)
//   rd_en_i       : pop the head at the rising edge (ignored while empty)
//   rd_data_o     : head entry, forced to zero while empty
//   empty_o       : no entries stored
//   full_o        : DEPTH entries stored
//   count_o       : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_array #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_wr, do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A write into a full FIFO is accepted only when the head leaves in the same edge.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/dot_product.sv
// dot_product: pipelined fixed-point 3-element dot product with output FIFO.
//   out = (x[0]*y[0] + x[1]*y[1] + x[2]*y[2]) >>> Q_BITS, low 32 bits kept.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   x, y         : operand vectors from an upstream FWFT FIFO
//   in_empty     : upstream FIFO empty
//   in_rd_en     : pops one x/y pair this cycle (combinational)
//   out          : head result of the output FIFO, zero while empty
//   out_empty    : output FIFO empty
//   out_rd_en    : pops the head result at the next rising edge
// Latency: pop -> products (edge 1) -> shifted sum (edge 2) -> FIFO write (edge 3).
module dot_product
    import dot_product_pkg::*;
#(
    parameter int Q_BITS    = Q_BITS_DEF,
    parameter int OUT_DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  vec3_t                    x,
    input  vec3_t                    y,
    input  logic                     in_empty,
    output logic                     in_rd_en,
    output logic signed [DATA_W-1:0] out,
    output logic                     out_empty,
    input  logic                     out_rd_en
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic signed [PROD_W-1:0] prod_d [VEC_LEN];
    logic signed [PROD_W-1:0] prod_q [VEC_LEN];
    logic                     v1_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic [DATA_W-1:0]        res_d, res_q;
    logic                     v2_q;

    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W-1:0]         free_slots;
    logic [CNT_W-1:0]         in_flight;
    logic                     fifo_full;
    logic [DATA_W-1:0]        fifo_head;

    // Credit check: every result already in the pipeline has a reserved slot,
    // so the FIFO can never be written while full.
    assign free_slots = CNT_W'(OUT_DEPTH) - fifo_count;
    assign in_flight  = CNT_W'(v1_q) + CNT_W'(v2_q);
    assign in_rd_en   = !reset && !in_empty && (free_slots > in_flight);

    always_comb begin
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
            prod_d[i] = PROD_W'($signed(x[i])) * PROD_W'($signed(y[i]));
        end
    end

    // Sign-extend each product before summing so three extreme terms cannot overflow.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
        res_d = DATA_W'(sum_d >>> Q_BITS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= in_rd_en;
            if (in_rd_en) begin
                for (int unsigned i = 0; i < VEC_LEN; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v2_q  <= 1'b0;
            res_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) res_q <= res_d;
        end
    end

    fifo_array #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i     (clock),
        .rst_i     (reset),
        .wr_en_i   (v2_q),
        .wr_data_i (res_q),
        .rd_en_i   (out_rd_en),
        .rd_data_o (fifo_head),
        .empty_o   (out_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    assign out = $signed(fifo_head);

    ap_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(v2_q && fifo_full && !(out_rd_en && !out_empty)));

endmodule

// File: tb/tb_dot_product.sv
module tb_dot_product;
    import dot_product_pkg::*;

    localparam int Q     = Q_BITS_DEF;
    localparam int DEPTH = 16;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     src_rst;
    logic                     src_wr;
    logic [191:0]             src_wdata;
    logic [191:0]             src_rdata;
    logic                     src_empty;
    logic                     src_full;
    logic [7:0]               src_count;
    vec3_t                    x, y;
    logic                     in_empty, in_rd_en;
    logic signed [DATA_W-1:0] out;
    logic                     out_empty, out_rd_en;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] exp_q [$];

    always #5 clock = ~clock;

    fifo_array #(
        .WIDTH (192),
        .DEPTH (128)
    ) u_src (
        .clk_i     (clock),
        .rst_i     (src_rst),
        .wr_en_i   (src_wr),
        .wr_data_i (src_wdata),
        .rd_en_i   (in_rd_en),
        .rd_data_o (src_rdata),
        .empty_o   (src_empty),
        .full_o    (src_full),
        .count_o   (src_count)
    );

    assign x        = src_rdata[95:0];
    assign y        = src_rdata[191:96];
    assign in_empty = src_empty;

    dot_product #(
        .Q_BITS    (Q),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out       (out),
        .out_empty (out_empty),
        .out_rd_en (out_rd_en)
    );

    function automatic logic [31:0] model(input vec3_t a, input vec3_t b);
        logic signed [127:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            acc = acc + 128'($signed(a[i])) * 128'($signed(b[i]));
        end
        return 32'(acc >>> Q);
    endfunction

    function automatic vec3_t rand_vec();
        vec3_t v;
        for (int i = 0; i < 3; i++) v[i] = $urandom;
        return v;
    endfunction

    function automatic vec3_t mk(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        vec3_t v;
        v[0] = a0; v[1] = a1; v[2] = a2;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: at the falling edge compare the head if it will be popped,
    // then set up read/write requests for the next rising edge.
    task automatic step(input bit rd, input bit wr, input vec3_t xv, input vec3_t yv,
                        input logic [31:0] ev);
        logic [31:0] e;
        @(negedge clock);
        if (rd && !out_empty) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_value", 64'($unsigned(out)), 64'(e));
            end
            pops++;
        end
        out_rd_en = rd;
        src_wr    = wr;
        src_wdata = {yv, xv};
        if (wr) exp_q.push_back(ev);
    endtask

    task automatic idle(input bit rd);
        step(rd, 1'b0, '0, '0, '0);
    endtask

    task automatic push(input bit rd, input vec3_t xv, input vec3_t yv, input logic [31:0] ev);
        step(rd, 1'b1, xv, yv, ev);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !out_empty) && n < 400) begin
            idle(1'b1);
            n++;
        end
        chk("drain_in_time", 64'(n < 400), 64'd1);
        repeat (4) idle(1'b1);
        chk("drain_empty", 64'(out_empty), 64'd1);
    endtask

    initial begin
        int    p0;
        vec3_t xv, yv;

        reset     = 1'b1;
        src_rst   = 1'b1;
        src_wr    = 1'b0;
        src_wdata = '0;
        out_rd_en = 1'b0;
        repeat (2) @(negedge clock);
        src_rst = 1'b0;

        // Load the basic vector upstream while the DUT is still held in reset.
        push(1'b0, mk(32'h400, 32'h800, 32'hC00), mk(32'h1000, 32'h1400, 32'h1800), 32'h0000_8000);
        idle(1'b0);
        #1;
        chk("rst_src_loaded", 64'(src_empty), 64'd0);
        chk("rst_in_rd_en", 64'(in_rd_en), 64'd0);
        chk("rst_out_empty", 64'(out_empty), 64'd1);
        chk("rst_out_zero", 64'($unsigned(out)), 64'd0);

        // Latency: pop on the first edge after release, visible three edges later.
        reset = 1'b0;
        #1;
        chk("lat_pop", 64'(in_rd_en), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            idle(1'b0);
            chk($sformatf("lat_cycle%0d", k), 64'(out_empty), (k == 3) ? 64'd0 : 64'd1);
        end
        chk("basic_fwft", 64'($unsigned(out)), 64'h8000);
        drain();

        // Sign and floor rounding.
        push(1'b0, mk(32'hFFFF_FC00, 0, 0), mk(32'h200, 0, 0), 32'hFFFF_FE00);
        push(1'b0, mk(32'h1, 0, 0), mk(32'h1, 0, 0), 32'h0000_0000);
        push(1'b0, mk(32'hFFFF_FFFF, 0, 0), mk(32'h1, 0, 0), 32'hFFFF_FFFF);
        drain();

        // Back-pressure: 100 random vectors with the output never read.
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            xv = rand_vec();
            yv = rand_vec();
            push(1'b0, xv, yv, model(xv, yv));
        end
        repeat (10) idle(1'b0);
        chk("bp_in_rd_en_low", 64'(in_rd_en), 64'd0);
        chk("bp_src_count", 64'(src_count), 64'(100 - DEPTH));
        chk("bp_src_not_full", 64'(src_full), 64'd0);
        chk("bp_out_nonempty", 64'(out_empty), 64'd0);
        drain();
        chk("bp_all_results", 64'(pops - p0), 64'd100);

        // Streaming with the output read every cycle; one overflow vector inside.
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                xv = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
                push(1'b1, xv, xv, 32'hFF40_0000);
            end else begin
                xv = rand_vec();
                yv = rand_vec();
                push(1'b1, xv, yv, model(xv, yv));
            end
        end
        chk("stream_rate", 64'(pops - p0), 64'd16);
        drain();

        // Reset with five results buffered: everything in flight is discarded.
        for (int i = 0; i < 5; i++) begin
            xv = rand_vec();
            yv = rand_vec();
            push(1'b0, xv, yv, model(xv, yv));
        end
        repeat (8) idle(1'b0);
        chk("mid_buffered", 64'(out_empty), 64'd0);
        reset   = 1'b1;
        src_rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_empty", 64'(out_empty), 64'd1);
        chk("mid_rst_out_zero", 64'($unsigned(out)), 64'd0);
        chk("mid_rst_in_rd_en", 64'(in_rd_en), 64'd0);
        @(negedge clock);
        reset   = 1'b0;
        src_rst = 1'b0;
        p0 = pops;
        push(1'b0, mk(32'h400, 0, 0), mk(32'h400, 0, 0), 32'h0000_0400);
        push(1'b0, mk(32'hFFFF_F800, 32'h400, 0), mk(32'h400, 32'h400, 0), 32'hFFFF_FC00);
        drain();
        chk("mid_post_count", 64'(pops - p0), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
